// File: rtl/double_ball_ctrl_pkg.sv
// rtl/double_ball_ctrl_pkg.sv - shared types and frame constants for the double-ball power-up
// Purpose: state encoding, counter width and default durations shared by the
//          controller and by game logic that reads double_active.
package dbl_pkg;

  typedef enum logic [1:0] {
    COOLDOWN = 2'd0,
    READY    = 2'd1,
    ACTIVE   = 2'd2
  } dbl_state_t;

  localparam int CNT_W = 12;

  localparam int DEF_COOLDOWN_FRAMES = 600;
  localparam int DEF_ACTIVE_FRAMES   = 480;
  localparam int DEF_BLINK_FRAMES    = 120;
  localparam int DEF_BLINK_HALF      = 8;

  // Frame countdown step that saturates at zero.
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/double_ball_ctrl_if.sv
// rtl/double_ball_ctrl_if.sv - game-side signal bundle of the double-ball controller
// Purpose: groups frame/key/goal inputs and icon/status outputs.
// Ports (signals): startOfFrame, game_run, key_dbN, goal_evt  -> controller
//                  icon_ena, double_active, frames_left, state_dbg <- controller
interface double_ball_ctrl_if;
  import dbl_pkg::*;

  logic             startOfFrame;
  logic             game_run;
  logic             key_dbN;
  logic             goal_evt;
  logic             icon_ena;
  logic             double_active;
  logic [CNT_W-1:0] frames_left;
  logic [1:0]       state_dbg;

  modport master (
    output startOfFrame, game_run, key_dbN, goal_evt,
    input  icon_ena, double_active, frames_left, state_dbg
  );

  modport slave (
    input  startOfFrame, game_run, key_dbN, goal_evt,
    output icon_ena, double_active, frames_left, state_dbg
  );
endinterface

// File: rtl/double_ball_ctrl_key_edge_sync.sv
// rtl/double_ball_ctrl_key_edge_sync.sv - key synchroniser with one-cycle falling-edge pulse
// Purpose: brings an asynchronous active-low button into the CLK domain and
//          emits a single press pulse per fall; a held key yields one pulse.
// Ports: CLK, RESETn (async active-low), key_n_i (raw pin), press_o (pulse)
module key_edge_sync (
  input  logic CLK,
  input  logic RESETn,
  input  logic key_n_i,
  output logic press_o
);

  // All flops reset to the released level so no press appears out of reset.
  logic sync1_q, sync2_q, last_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      last_q  <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
    end
  end

  // Decoded from flops only, so the consumer acts on the third edge after the fall.
  assign press_o = last_q & ~sync2_q;

endmodule

// File: rtl/double_ball_ctrl.sv
// rtl/double_ball_ctrl.sv - cooldown / ready / active sequencer for the double-ball power-up
// Purpose: counts frames through cooldown, offers the icon, runs the active
//          double-ball period with a blinking icon near its end.
// Ports: CLK, RESETn (async active-low), bus (double_ball_ctrl_if.slave)
module double_ball_ctrl
  import dbl_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
  parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
  parameter int BLINK_HALF      = DEF_BLINK_HALF
) (
  input  logic CLK,
  input  logic RESETn,
  double_ball_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CD_C  = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] ACT_C = CNT_W'(ACTIVE_FRAMES);
  localparam logic [CNT_W-1:0] BLK_C = CNT_W'(BLINK_FRAMES);
  localparam logic [8:0]       BH_C  = 9'(BLINK_HALF);
  localparam logic [8:0]       BPM_C = 9'(2 * BLINK_HALF - 1);

  logic press;
  logic tick;

  key_edge_sync u_key (
    .CLK    (CLK),
    .RESETn (RESETn),
    .key_n_i(bus.key_dbN),
    .press_o(press)
  );

  assign tick = bus.startOfFrame & bus.game_run;

  dbl_state_t       state_q, state_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [8:0]       blink_q, blink_d;
  logic             icon_q, icon_d;
  logic             double_q, double_d;

  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    blink_d  = blink_q;
    case (state_q)
      COOLDOWN: begin
        if (tick) begin
          if (frames_q <= CNT_W'(1)) begin
            state_d  = READY;
            frames_d = '0;
          end else begin
            frames_d = dec_sat(frames_q);
          end
        end
      end
      READY: begin
        // A press while paused is dropped, not held for later.
        if (press && bus.game_run) begin
          state_d  = ACTIVE;
          frames_d = ACT_C;
          blink_d  = '0;
        end
      end
      ACTIVE: begin
        // A goal wins over a coincident expiry tick; both land in a fresh cooldown.
        if (bus.goal_evt) begin
          state_d  = COOLDOWN;
          frames_d = CD_C;
        end else if (tick) begin
          if (frames_q <= CNT_W'(1)) begin
            state_d  = COOLDOWN;
            frames_d = CD_C;
          end else begin
            frames_d = dec_sat(frames_q);
            // Blink phase restarts exactly when the blink window opens.
            if (frames_d == BLK_C)     blink_d = '0;
            else if (blink_q >= BPM_C) blink_d = '0;
            else                       blink_d = blink_q + 9'd1;
          end
        end
      end
      default: begin
        state_d  = COOLDOWN;
        frames_d = CD_C;
      end
    endcase

    double_d = (state_d == ACTIVE);
    icon_d   = (state_d == READY) ||
               ((state_d == ACTIVE) && ((frames_d > BLK_C) || (blink_d < BH_C)));
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= COOLDOWN;
      frames_q <= CD_C;
      blink_q  <= '0;
      icon_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      blink_q  <= blink_d;
      icon_q   <= icon_d;
      double_q <= double_d;
    end
  end

  assign bus.icon_ena      = icon_q;
  assign bus.double_active = double_q;
  assign bus.frames_left   = frames_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_double_ball_ctrl.sv
// tb/tb_double_ball_ctrl.sv - self-checking bench for double_ball_ctrl
module tb_double_ball_ctrl;
  import dbl_pkg::*;

  localparam int CDF = 4;
  localparam int ACT = 6;
  localparam int BLK = 3;
  localparam int BH  = 1;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;

  double_ball_ctrl_if bus();

  double_ball_ctrl #(
    .COOLDOWN_FRAMES(CDF),
    .ACTIVE_FRAMES  (ACT),
    .BLINK_FRAMES   (BLK),
    .BLINK_HALF     (BH)
  ) dut (
    .CLK   (CLK),
    .RESETn(RESETn),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = cooldown, 1 = ready, 2 = active.
  int m_st;
  int m_left;
  bit h1, h2, h3; // pin level seen at the previous three clock edges

  function automatic int m_icon();
    if (m_st == 1) return 1;
    if (m_st != 2) return 0;
    if (m_left > BLK) return 1;
    // Frames elapsed inside the blink window decide the visible half-period.
    return (((BLK - m_left) / BH) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = CDF; h1 = 1; h2 = 1; h3 = 1;
  endtask

  task automatic model_edge();
    bit tick, press;
    tick  = bus.startOfFrame && bus.game_run;
    press = (h2 == 1'b0) && (h3 == 1'b1);
    if (m_st == 2 && bus.goal_evt) begin
      m_st = 0; m_left = CDF;
    end else if (m_st == 0) begin
      if (tick) begin
        m_left = m_left - 1;
        if (m_left == 0) m_st = 1;
      end
    end else if (m_st == 1) begin
      if (press && bus.game_run) begin m_st = 2; m_left = ACT; end
    end else begin
      if (tick) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_st = 0; m_left = CDF; end
      end
    end
    h3 = h2; h2 = h1; h1 = bus.key_dbN;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_state"},  32'(bus.state_dbg),     32'(m_st));
    chk({tag, "_left"},   32'(bus.frames_left),   32'(m_left));
    chk({tag, "_icon"},   32'(bus.icon_ena),      32'(m_icon()));
    chk({tag, "_double"}, 32'(bus.double_active), 32'(m_st == 2));
  endtask

  task automatic step(input bit sof, input bit goal, input bit run, input bit key);
    bus.startOfFrame = sof;
    bus.goal_evt     = goal;
    bus.game_run     = run;
    bus.key_dbN      = key;
    @(posedge CLK);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  // One frame pulse followed by two idle cycles.
  task automatic frame(input bit run);
    step(1'b1, 1'b0, run, 1'b1);
    step(1'b0, 1'b0, run, 1'b1);
    step(1'b0, 1'b0, run, 1'b1);
  endtask

  task automatic press_key();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    bus.startOfFrame = 1'b0;
    bus.goal_evt     = 1'b0;
    bus.game_run     = 1'b1;
    bus.key_dbN      = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RESETn = 1'b1;

    // 1: cooldown countdown into READY.
    for (int i = 0; i < CDF; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("t1_left", 32'(bus.frames_left), 32'(CDF - 1 - i));
      step(1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("t1_state", 32'(bus.state_dbg), 32'd1);
    chk("t1_icon", 32'(bus.icon_ena), 32'd1);

    // 2: held key activates exactly once on the third edge after the fall.
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 1) chk("t2_not_yet", 32'(bus.state_dbg), 32'd1);
      if (i == 2) begin
        chk("t2_active", 32'(bus.state_dbg), 32'd2);
        chk("t2_double", 32'(bus.double_active), 32'd1);
        chk("t2_left", 32'(bus.frames_left), 32'(ACT));
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

    // 3: full active period with blink pattern, then expiry.
    begin
      logic [5:0] exp_icon;
      exp_icon = 6'b010111; // bit i = icon after pulse i+1
      for (int i = 0; i < ACT; i++) begin
        frame(1'b1);
        chk("t3_icon", 32'(bus.icon_ena), 32'(exp_icon[i]));
      end
    end
    chk("t3_state", 32'(bus.state_dbg), 32'd0);
    chk("t3_left", 32'(bus.frames_left), 32'(CDF));
    chk("t3_double", 32'(bus.double_active), 32'd0);

    // 4: goal coincident with a frame pulse in ACTIVE.
    for (int i = 0; i < CDF; i++) frame(1'b1);
    press_key();
    frame(1'b1);
    chk("t4_pre_left", 32'(bus.frames_left), 32'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_state", 32'(bus.state_dbg), 32'd0);
    chk("t4_left", 32'(bus.frames_left), 32'(CDF));

    // 5: pause in ACTIVE freezes counting and ignores the key.
    for (int i = 0; i < CDF; i++) frame(1'b1);
    press_key();
    frame(1'b1);
    frame(1'b1);
    frame(1'b1);
    begin
      logic [CNT_W-1:0] held_left;
      logic             held_icon;
      held_left = bus.frames_left;
      held_icon = bus.icon_ena;
      for (int i = 0; i < 10; i++) frame(1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_left", 32'(bus.frames_left), 32'(held_left));
      chk("t5_icon", 32'(bus.icon_ena), 32'(held_icon));
      chk("t5_state", 32'(bus.state_dbg), 32'd2);
      frame(1'b1);
      chk("t5_resume", 32'(bus.frames_left), 32'(held_left) - 32'd1);
    end

    // 6: asynchronous reset mid-ACTIVE, then a full cooldown again.
    #3;
    RESETn = 1'b0;
    #1;
    chk("t6_double", 32'(bus.double_active), 32'd0);
    chk("t6_icon", 32'(bus.icon_ena), 32'd0);
    chk("t6_state", 32'(bus.state_dbg), 32'd0);
    chk("t6_left", 32'(bus.frames_left), 32'(CDF));
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    RESETn = 1'b1;
    for (int i = 0; i < CDF; i++) frame(1'b1);
    chk("t6_ready", 32'(bus.state_dbg), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit sof, goal, run, key;
      sof  = ($urandom_range(0, 3) == 0);
      goal = ($urandom_range(0, 29) == 0);
      run  = ($urandom_range(0, 7) != 0);
      key  = ($urandom_range(0, 9) < 7) ? bus.key_dbN : ~bus.key_dbN;
      step(sof, goal, run, key);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
